// File: rtl/vslc_timer_pkg.sv
// Shared mode constants and channel state encoding for the VSLC multi-channel timer.
package vslc_timer_pkg;

   localparam logic [1:0] MODE_CONT    = 2'b00;
   localparam logic [1:0] MODE_ONESHOT = 2'b01;
   localparam logic [1:0] MODE_GATED   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PH_A = 2'd1,
      ST_PH_B = 2'd2
   } chan_state_t;

   // Reserved mode 11 falls back to free-running, so only ONESHOT stops after phase B.
   function automatic logic mode_repeats(input logic [1:0] m);
      return (m != MODE_ONESHOT);
   endfunction

endpackage

// File: rtl/vslc_timer_channel.sv
// One two-phase timer channel: low for (A+1) ticks, high for (B+1) ticks,
// with shadowed periods/mode, one-shot edge detect and gated counting.
module vslc_timer_channel
   import vslc_timer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] period_a,
   input  logic [WIDTH-1:0] period_b,
   input  logic             trigger,
   output logic             timer_out,
   output logic             done,
   output logic             busy
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   chan_state_t      state_reg;
   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] shadow_a_reg;
   logic [WIDTH-1:0] shadow_b_reg;
   logic [1:0]       shadow_mode_reg;
   logic             trig_prev_reg;
   logic             timer_out_reg;
   logic             done_reg;
   logic             busy_reg;

   logic trig_rise;
   logic count_en;

   assign trig_rise = trigger & ~trig_prev_reg;
   // A gated channel ignores ticks while its trigger is low; others always count.
   assign count_en  = tick & ((shadow_mode_reg != MODE_GATED) | trigger);

   always_ff @(posedge clk) begin
      if (!rst_n || !enable) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         shadow_a_reg    <= '0;
         shadow_b_reg    <= '0;
         shadow_mode_reg <= MODE_CONT;
         trig_prev_reg   <= 1'b0;
         timer_out_reg   <= 1'b0;
         done_reg        <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         trig_prev_reg <= trigger;
         done_reg      <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (mode_repeats(mode) || trig_rise) begin
                  shadow_a_reg    <= period_a;
                  shadow_b_reg    <= period_b;
                  shadow_mode_reg <= mode;
                  cnt_reg         <= '0;
                  state_reg       <= ST_PH_A;
                  timer_out_reg   <= 1'b0;
                  busy_reg        <= 1'b1;
               end
            end
            ST_PH_A: begin
               if (count_en) begin
                  if (cnt_reg == shadow_a_reg) begin
                     cnt_reg       <= '0;
                     state_reg     <= ST_PH_B;
                     timer_out_reg <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + CNT_ONE;
                  end
               end
            end
            ST_PH_B: begin
               if (count_en) begin
                  if (cnt_reg == shadow_b_reg) begin
                     cnt_reg       <= '0;
                     done_reg      <= 1'b1;
                     timer_out_reg <= 1'b0;
                     // A one-shot edge landing on the final tick restarts without passing through idle.
                     if (mode_repeats(shadow_mode_reg) || trig_rise) begin
                        shadow_a_reg    <= period_a;
                        shadow_b_reg    <= period_b;
                        shadow_mode_reg <= mode;
                        state_reg       <= ST_PH_A;
                        busy_reg        <= 1'b1;
                     end else begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CNT_ONE;
                  end
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               cnt_reg       <= '0;
               timer_out_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign timer_out = timer_out_reg;
   assign done      = done_reg;
   assign busy      = busy_reg;

endmodule

// File: rtl/vslc_multi_timer.sv
// Multi-channel two-phase timer: one shared prescaler tick feeding CHANNELS
// independent timer channels sliced from packed configuration buses.
module vslc_multi_timer
   import vslc_timer_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int PRE_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [PRE_W-1:0]          prescale,
   input  logic [CHANNELS-1:0]       enable,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS*WIDTH-1:0] period_a,
   input  logic [CHANNELS*WIDTH-1:0] period_b,
   input  logic [CHANNELS-1:0]       trigger,
   output logic [CHANNELS-1:0]       timer_out,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS-1:0]       busy
);

   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

   logic [PRE_W-1:0] pre_cnt_reg;
   logic             tick;

   // Comparing with >= lets a lowered prescale take effect at once instead of wrapping.
   assign tick = (pre_cnt_reg >= prescale);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt_reg <= '0;
      end else if (tick) begin
         pre_cnt_reg <= '0;
      end else begin
         pre_cnt_reg <= pre_cnt_reg + PRE_ONE;
      end
   end

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         vslc_timer_channel #(
            .WIDTH (WIDTH)
         ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .enable    (enable[gi]),
            .mode      (mode[2*gi +: 2]),
            .period_a  (period_a[WIDTH*gi +: WIDTH]),
            .period_b  (period_b[WIDTH*gi +: WIDTH]),
            .trigger   (trigger[gi]),
            .timer_out (timer_out[gi]),
            .done      (done[gi]),
            .busy      (busy[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_vslc_multi_timer.sv
// Directed bench for vslc_multi_timer: a per-clock vector table for the
// continuous/reset case plus hand-written multi-cycle sequences.
module tb_vslc_multi_timer;

   localparam int WIDTH    = 16;
   localparam int CHANNELS = 4;
   localparam int PRE_W    = 8;

   logic                      clk;
   logic                      rst_n;
   logic [PRE_W-1:0]          prescale;
   logic [CHANNELS-1:0]       enable;
   logic [2*CHANNELS-1:0]     mode;
   logic [CHANNELS*WIDTH-1:0] period_a;
   logic [CHANNELS*WIDTH-1:0] period_b;
   logic [CHANNELS-1:0]       trigger;
   logic [CHANNELS-1:0]       timer_out;
   logic [CHANNELS-1:0]       done;
   logic [CHANNELS-1:0]       busy;

   int vectors;
   int miscompares;

   vslc_multi_timer #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .PRE_W    (PRE_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .prescale  (prescale),
      .enable    (enable),
      .mode      (mode),
      .period_a  (period_a),
      .period_b  (period_b),
      .trigger   (trigger),
      .timer_out (timer_out),
      .done      (done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] en;
      logic [3:0] trig;
      logic [3:0] exp_out;
      logic [3:0] exp_done;
      logic [3:0] exp_busy;
   } vec_t;

   vec_t vecs [13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic set_pa(input int ch, input logic [WIDTH-1:0] v);
      period_a[WIDTH*ch +: WIDTH] = v;
   endtask

   task automatic set_pb(input int ch, input logic [WIDTH-1:0] v);
      period_b[WIDTH*ch +: WIDTH] = v;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n    = 1'b0;
      prescale = '0;
      enable   = '0;
      mode     = '0;
      period_a = '0;
      period_b = '0;
      trigger  = '0;

      // CONT ch0, A=2 B=1, prescale 0: low 3, high 2, done every 5 clk; reset mid-phase at the end.
      //             rst   en       trig     out      done     busy
      vecs[0]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[1]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      vecs[2]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      vecs[3]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      vecs[4]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      vecs[5]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      vecs[6]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
      vecs[7]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      vecs[8]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
      vecs[9]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      vecs[10] = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      vecs[11] = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
      vecs[12] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

      set_pa(0, 16'd2);
      set_pb(0, 16'd1);
      for (int v = 0; v < 13; v++) begin
         rst_n   = vecs[v].rst_n;
         enable  = vecs[v].en;
         trigger = vecs[v].trig;
         step();
         chk($sformatf("vec%0d timer_out", v), 16'(timer_out), 16'(vecs[v].exp_out));
         chk($sformatf("vec%0d done", v),      16'(done),      16'(vecs[v].exp_done));
         chk($sformatf("vec%0d busy", v),      16'(busy),      16'(vecs[v].exp_busy));
      end

      // Prescaler: ch1 A=0 B=0, prescale 3 -> 4 clk per phase; then lower prescale mid-count.
      enable   = '0;
      mode     = '0;
      period_a = '0;
      period_b = '0;
      prescale = 8'd3;
      do_reset();
      enable = 4'b0010;
      step();
      chk("pre start busy", 16'(busy[1]), 16'd1);
      step_n(3);
      chk("pre ph_b rise", 16'(timer_out[1]), 16'd1);
      step_n(3);
      chk("pre ph_b hold", 16'(timer_out[1]), 16'd1);
      step();
      chk("pre ph_b end out", 16'(timer_out[1]), 16'd0);
      chk("pre ph_b end done", 16'(done[1]), 16'd1);
      step();
      chk("pre done pulse width", 16'(done[1]), 16'd0);
      step_n(3);
      chk("pre second ph_b", 16'(timer_out[1]), 16'd1);
      step_n(2);
      prescale = 8'd1;
      step();
      chk("pre lowered tick done", 16'(done[1]), 16'd1);
      chk("pre lowered tick out", 16'(timer_out[1]), 16'd0);
      step();
      chk("pre new rate low", 16'(timer_out[1]), 16'd0);
      step();
      chk("pre new rate high", 16'(timer_out[1]), 16'd1);

      // ONESHOT ch2 A=4 B=2: pulse run, ignored mid-run edge, restart on done clk.
      enable   = '0;
      prescale = '0;
      mode     = 8'b00_01_00_00;
      set_pa(2, 16'd4);
      set_pb(2, 16'd2);
      trigger  = '0;
      do_reset();
      enable = 4'b0100;
      step();
      chk("os idle busy", 16'(busy[2]), 16'd0);
      trigger[2] = 1'b1;
      step();
      chk("os start busy", 16'(busy[2]), 16'd1);
      trigger[2] = 1'b0;
      step();
      trigger[2] = 1'b1;
      step();
      trigger[2] = 1'b0;
      step_n(2);
      chk("os ph_a low", 16'(timer_out[2]), 16'd0);
      step();
      chk("os ph_b high", 16'(timer_out[2]), 16'd1);
      step_n(2);
      chk("os ph_b last", 16'(timer_out[2]), 16'd1);
      step();
      chk("os done", 16'(done[2]), 16'd1);
      chk("os done busy", 16'(busy[2]), 16'd0);
      chk("os done out", 16'(timer_out[2]), 16'd0);
      step();
      chk("os stays idle", 16'(busy[2]), 16'd0);
      chk("os done once", 16'(done[2]), 16'd0);
      trigger[2] = 1'b1;
      step();
      trigger[2] = 1'b0;
      step_n(7);
      chk("os rerun ph_b", 16'(timer_out[2]), 16'd1);
      trigger[2] = 1'b1;
      step();
      chk("os restart done", 16'(done[2]), 16'd1);
      chk("os restart busy", 16'(busy[2]), 16'd1);
      trigger[2] = 1'b0;
      step_n(4);
      chk("os restart ph_a", 16'(timer_out[2]), 16'd0);
      step();
      chk("os restart ph_b", 16'(timer_out[2]), 16'd1);

      // GATED ch3 A=5: trigger low for 10 clk after two counted ticks.
      enable   = '0;
      mode     = 8'b10_00_00_00;
      set_pa(3, 16'd5);
      set_pb(3, 16'd1);
      trigger  = 4'b1000;
      do_reset();
      enable = 4'b1000;
      step_n(3);
      trigger[3] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("gate pause%0d out", i), 16'(timer_out[3]), 16'd0);
      end
      chk("gate pause busy", 16'(busy[3]), 16'd1);
      trigger[3] = 1'b1;
      step_n(3);
      chk("gate resume ph_a", 16'(timer_out[3]), 16'd0);
      step();
      chk("gate ph_b after 6 ticks", 16'(timer_out[3]), 16'd1);

      // Shadowing: period_b 1 -> 7 during PH_B applies only to the next PH_B.
      enable   = '0;
      mode     = '0;
      trigger  = '0;
      set_pa(0, 16'd2);
      set_pb(0, 16'd1);
      do_reset();
      enable = 4'b0001;
      step_n(4);
      chk("shadow ph_b entry", 16'(timer_out[0]), 16'd1);
      set_pb(0, 16'd7);
      step();
      chk("shadow ph_b hold", 16'(timer_out[0]), 16'd1);
      step();
      chk("shadow old ph_b end", 16'(done[0]), 16'd1);
      step_n(2);
      chk("shadow ph_a", 16'(timer_out[0]), 16'd0);
      step();
      chk("shadow new ph_b start", 16'(timer_out[0]), 16'd1);
      step_n(7);
      chk("shadow long ph_b", 16'(timer_out[0]), 16'd1);
      step();
      chk("shadow long ph_b done", 16'(done[0]), 16'd1);
      chk("shadow long ph_b out", 16'(timer_out[0]), 16'd0);

      // Enable drop on ch0 only while all four run.
      enable = '0;
      mode   = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         set_pa(c, 16'd1);
         set_pb(c, 16'd1);
      end
      do_reset();
      enable = 4'b1111;
      step_n(3);
      chk("en all busy", 16'(busy), 16'hf);
      enable = 4'b1110;
      step();
      chk("en drop busy", 16'(busy), 16'he);
      chk("en drop out0", 16'(timer_out[0]), 16'd0);
      step();
      chk("en others running", 16'(busy[3:1]), 16'h7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
